clk_div_ctrl: RTL and testbench

Programmable, glitch-free clock divider controller for the board's system clock (e.g. 50 MHz). It generates a divided clock-like output `clk_out` with a run-time configurable half-period, starts and stops cleanly, and lets software change the ratio through a req/ack handshake. The ratio change takes effect only at a safe phase boundary, so no runt pulse is ever produced. It replaces fixed toggle dividers feeding 25/12.5/5/1 MHz consumers.

---
 rtl/clk_div_ctrl_if.sv | 24 ++
 rtl/clk_div_ctrl.sv | 140 ++++++++++++++
 tb/tb_clk_div_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_ctrl_if.sv
// Control/status bundle for clk_div_ctrl: run request, config handshake and
// the divided clock outputs.
interface clk_div_ctrl_if #(
  parameter int WIDTH = 5
);
  logic             en;
  logic             cfg_req;
  logic [WIDTH-1:0] cfg_half;
  logic             cfg_ack;
  logic             busy;
  logic             clk_out;
  logic             tick_rise;
  logic             tick_fall;

  modport master (
    output en, cfg_req, cfg_half,
    input  cfg_ack, busy, clk_out, tick_rise, tick_fall
  );

  modport slave (
    input  en, cfg_req, cfg_half,
    output cfg_ack, busy, clk_out, tick_rise, tick_fall
  );
endinterface

// File: rtl/clk_div_ctrl.sv
// Glitch-free programmable clock divider with req/ack ratio change.
// Optional macro CLK_DIV_CTRL_TICK_EN enables the tick_rise/tick_fall strobes.
module clk_div_ctrl #(
  parameter int               WIDTH        = 5,
  parameter logic [WIDTH-1:0] DEFAULT_HALF = '0
) (
  input  logic          clk,
  input  logic          rst,
  clk_div_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] half_reg, half_next;
  logic [WIDTH-1:0] pend_half_reg, pend_half_next;
  logic             pend_reg, pend_next;
  logic             clk_out_reg, clk_out_next;
  logic             ack_reg, ack_next;
  logic             req_q_reg;
  logic             at_end;
  logic             apply;

  assign at_end = (cnt_reg == half_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      half_reg      <= DEFAULT_HALF;
      pend_half_reg <= '0;
      pend_reg      <= 1'b0;
      clk_out_reg   <= 1'b0;
      ack_reg       <= 1'b0;
      req_q_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      half_reg      <= half_next;
      pend_half_reg <= pend_half_next;
      pend_reg      <= pend_next;
      clk_out_reg   <= clk_out_next;
      ack_reg       <= ack_next;
      req_q_reg     <= bus.cfg_req;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    half_next      = half_reg;
    pend_half_next = pend_half_reg;
    pend_next      = pend_reg;
    clk_out_next   = clk_out_reg;
    ack_next       = 1'b0;
    apply          = 1'b0;

    case (state_reg)
      IDLE: begin
        cnt_next     = '0;
        clk_out_next = 1'b0;
        apply        = pend_reg;
        if (bus.en) begin
          state_next   = RUN;
          clk_out_next = 1'b1;
        end
      end
      RUN: begin
        if (!bus.en && !clk_out_reg) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (at_end) begin
          cnt_next     = '0;
          clk_out_next = ~clk_out_reg;
          if (clk_out_reg) begin
            if (!bus.en)
              state_next = IDLE;
          end else begin
            // Rising toggle: the only safe point to switch ratio while running.
            apply = pend_reg;
          end
        end else begin
          cnt_next = cnt_reg + WIDTH'(1);
          if (!bus.en)
            state_next = STOP;
        end
      end
      STOP: begin
        if (at_end) begin
          cnt_next     = '0;
          clk_out_next = 1'b0;
          state_next   = IDLE;
        end else begin
          cnt_next = cnt_reg + WIDTH'(1);
        end
      end
      default: begin
        state_next   = IDLE;
        cnt_next     = '0;
        clk_out_next = 1'b0;
      end
    endcase

    if (apply) begin
      half_next = pend_half_reg;
      pend_next = 1'b0;
      ack_next  = 1'b1;
    end

    // Capture and apply are mutually exclusive since apply needs pend_reg set.
    if (bus.cfg_req && !req_q_reg && !pend_reg) begin
      pend_next      = 1'b1;
      pend_half_next = bus.cfg_half;
    end
  end

  assign bus.clk_out = clk_out_reg;
  assign bus.cfg_ack = ack_reg;
  assign bus.busy    = pend_reg;

`ifdef CLK_DIV_CTRL_TICK_EN
  logic tick_rise_reg, tick_fall_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_rise_reg <= 1'b0;
      tick_fall_reg <= 1'b0;
    end else begin
      tick_rise_reg <= clk_out_next & ~clk_out_reg;
      tick_fall_reg <= ~clk_out_next & clk_out_reg;
    end
  end

  assign bus.tick_rise = tick_rise_reg;
  assign bus.tick_fall = tick_fall_reg;
`else
  assign bus.tick_rise = 1'b0;
  assign bus.tick_fall = 1'b0;
`endif
endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: vector table, directed corner cases,
// and randomized traffic against a phase-countdown reference model.
module tb_clk_div_ctrl;
  localparam int WIDTH = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  clk_div_ctrl_if #(.WIDTH(WIDTH)) bus ();

  clk_div_ctrl #(
    .WIDTH       (WIDTH),
    .DEFAULT_HALF(5'd0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model: tracks output level and how many cycles remain in the
  // current phase, counting down instead of up.
  int m_level, m_active, m_stop, m_left, m_half, m_pv, m_pval, m_rq;
  int m_ack, m_tr, m_tf;

  typedef struct {
    logic             en;
    logic             req;
    logic [WIDTH-1:0] half;
    logic [4:0]       exp;
  } vec_t;

  vec_t tbl[23];

  task automatic m_reset();
    m_level = 0; m_active = 0; m_stop = 0; m_left = 0; m_half = 0;
    m_pv = 0; m_pval = 0; m_rq = 0; m_ack = 0; m_tr = 0; m_tf = 0;
  endtask

  task automatic m_step(input logic en, input logic req, input int h);
    bit cap;
    cap = req && (m_rq == 0) && (m_pv == 0);
    m_ack = 0; m_tr = 0; m_tf = 0;
    if (m_active == 0) begin
      if (m_pv != 0) begin
        m_half = m_pval; m_pv = 0; m_ack = 1;
      end
      if (en) begin
        m_active = 1; m_level = 1; m_tr = 1; m_left = m_half + 1;
      end
    end else if (m_stop == 0 && !en && m_level == 0) begin
      m_active = 0;
    end else begin
      if (!en) m_stop = 1;
      m_left = m_left - 1;
      if (m_left == 0) begin
        if (m_level != 0) begin
          m_level = 0; m_tf = 1;
          if (m_stop != 0) begin
            m_active = 0; m_stop = 0;
          end else begin
            m_left = m_half + 1;
          end
        end else begin
          if (m_pv != 0) begin
            m_half = m_pval; m_pv = 0; m_ack = 1;
          end
          m_level = 1; m_tr = 1; m_left = m_half + 1;
        end
      end
    end
    if (cap) begin
      m_pv = 1; m_pval = h;
    end
    m_rq = req;
  endtask

  function automatic logic [4:0] mask_ticks(input logic [4:0] v);
    logic [4:0] r;
    r = v;
`ifndef CLK_DIV_CTRL_TICK_EN
    r[3] = 1'b0;
    r[2] = 1'b0;
`endif
    return r;
  endfunction

  function automatic logic [4:0] act_vec();
    return {bus.clk_out, bus.tick_rise, bus.tick_fall, bus.cfg_ack, bus.busy};
  endfunction

  function automatic logic [4:0] model_vec();
    return mask_ticks({m_level != 0, m_tr != 0, m_tf != 0, m_ack != 0, m_pv != 0});
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
      $display("ok   %s got=%0h", name, act);
    end else begin
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs, take the edge, advance the model.
  task automatic step(input logic en, input logic req, input logic [WIDTH-1:0] h);
    bus.en = en; bus.cfg_req = req; bus.cfg_half = h;
    @(posedge clk);
    #1;
    m_step(en, req, int'(h));
  endtask

  task automatic step_chk(input string name, input logic en, input logic req,
                          input logic [WIDTH-1:0] h);
    step(en, req, h);
    check(name, act_vec(), model_vec());
  endtask

  task automatic do_reset();
    bus.en = 1'b0; bus.cfg_req = 1'b0; bus.cfg_half = '0;
    rst = 1'b1;
    #1;
    m_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int cnt_a, cnt_b, acks;
    logic [WIDTH-1:0] rh;
    logic ren, rreq;
    logic c_arr[12];
    logic a_arr[12];

    //            en    req   half   {clk,tr,tf,ack,busy}
    tbl[0]  = '{1'b1, 1'b0, 5'd0, 5'b11000};
    tbl[1]  = '{1'b1, 1'b0, 5'd0, 5'b00100};
    tbl[2]  = '{1'b1, 1'b0, 5'd0, 5'b11000};
    tbl[3]  = '{1'b1, 1'b0, 5'd0, 5'b00100};
    tbl[4]  = '{1'b0, 1'b0, 5'd0, 5'b00000};
    tbl[5]  = '{1'b0, 1'b0, 5'd0, 5'b00000};
    tbl[6]  = '{1'b0, 1'b1, 5'd2, 5'b00001};
    tbl[7]  = '{1'b0, 1'b1, 5'd2, 5'b00010};
    tbl[8]  = '{1'b0, 1'b0, 5'd2, 5'b00000};
    tbl[9]  = '{1'b1, 1'b0, 5'd2, 5'b11000};
    tbl[10] = '{1'b1, 1'b0, 5'd2, 5'b10000};
    tbl[11] = '{1'b1, 1'b0, 5'd2, 5'b10000};
    tbl[12] = '{1'b1, 1'b0, 5'd2, 5'b00100};
    tbl[13] = '{1'b1, 1'b0, 5'd2, 5'b00000};
    tbl[14] = '{1'b1, 1'b0, 5'd2, 5'b00000};
    tbl[15] = '{1'b1, 1'b0, 5'd2, 5'b11000};
    tbl[16] = '{1'b0, 1'b0, 5'd2, 5'b10000};
    tbl[17] = '{1'b1, 1'b0, 5'd2, 5'b10000};
    tbl[18] = '{1'b1, 1'b0, 5'd2, 5'b00100};
    tbl[19] = '{1'b0, 1'b0, 5'd2, 5'b00000};
    tbl[20] = '{1'b0, 1'b1, 5'd3, 5'b00001};
    tbl[21] = '{1'b1, 1'b1, 5'd3, 5'b11010};
    tbl[22] = '{1'b1, 1'b0, 5'd3, 5'b10000};

    bus.en = 1'b0; bus.cfg_req = 1'b0; bus.cfg_half = '0;
    m_reset();
    #12;
    check("reset_state", act_vec(), 5'b00000);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 23; i++) begin
      step(tbl[i].en, tbl[i].req, tbl[i].half);
      check($sformatf("tbl[%0d]", i), act_vec(), mask_ticks(tbl[i].exp));
    end

    // /50 configured in IDLE: ack two cycles after the request edge.
    do_reset();
    step(1'b0, 1'b1, 5'd24);
    check("A_busy", act_vec(), 5'b00001);
    step(1'b0, 1'b1, 5'd24);
    check("A_ack", act_vec(), 5'b00010);
    step_chk("A_idle", 1'b0, 1'b0, 5'd24);
    cnt_a = 0; cnt_b = 0;
    for (int k = 0; k < 50; k++) begin
      step_chk($sformatf("A_run[%0d]", k), 1'b1, 1'b0, 5'd24);
      if (k < 25) cnt_a += int'(bus.clk_out);
      else        cnt_b += int'(bus.clk_out);
    end
    check("A_high_len", cnt_a, 25);
    check("A_low_high_cycles", cnt_b, 0);

    // Ratio change 1 -> 4 requested mid-high.
    do_reset();
    step(1'b0, 1'b1, 5'd1);
    step_chk("B_cfg", 1'b0, 1'b0, 5'd1);
    step_chk("B_start", 1'b1, 1'b0, 5'd1);
    step(1'b1, 1'b1, 5'd4);
    check("B_capture", act_vec(), 5'b10001);
    for (int k = 0; k < 12; k++) begin
      step_chk($sformatf("B_run[%0d]", k), 1'b1, 1'b1, 5'd4);
      c_arr[k] = bus.clk_out;
      a_arr[k] = bus.cfg_ack;
    end
    check("B_low_phase", {c_arr[0], c_arr[1], c_arr[2]}, 3'b001);
    check("B_ack_at_rise", {c_arr[2], a_arr[2], a_arr[1], a_arr[3]}, 4'b1100);
    cnt_a = 0;
    for (int k = 2; k < 7; k++) cnt_a += int'(c_arr[k]);
    check("B_high_len", {cnt_a[3:0], c_arr[7]}, {4'd5, 1'b0});

    // Stop request during the high phase at /10.
    do_reset();
    step(1'b0, 1'b1, 5'd4);
    step_chk("C_cfg", 1'b0, 1'b0, 5'd4);
    cnt_a = 0;
    step_chk("C_hi1", 1'b1, 1'b0, 5'd4);
    cnt_a += int'(bus.clk_out);
    step_chk("C_hi2", 1'b1, 1'b0, 5'd4);
    cnt_a += int'(bus.clk_out);
    for (int k = 0; k < 10; k++) begin
      step_chk($sformatf("C_stop[%0d]", k), 1'b0, 1'b0, 5'd4);
      cnt_a += int'(bus.clk_out);
    end
    check("C_high_total", cnt_a, 5);

    // Reset while a config is pending in RUN.
    do_reset();
    step(1'b0, 1'b1, 5'd3);
    step_chk("D_cfg", 1'b0, 1'b0, 5'd3);
    step_chk("D_start", 1'b1, 1'b0, 5'd3);
    step(1'b1, 1'b1, 5'd6);
    check("D_pending", act_vec(), 5'b10001);
    #3;
    rst = 1'b1;
    #1;
    check("D_async_rst", act_vec(), 5'b00000);
    m_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    acks = 0; cnt_a = 0;
    for (int k = 0; k < 20; k++) begin
      step_chk($sformatf("D_run[%0d]", k), 1'b1, 1'b0, 5'd6);
      acks += int'(bus.cfg_ack);
      cnt_a += int'(bus.clk_out);
    end
    check("D_no_ack", acks, 0);
    check("D_default_half", cnt_a, 10);

    // Randomized traffic against the model.
    do_reset();
    ren = 1'b0; rreq = 1'b0; rh = '0;
    for (int k = 0; k < 1000; k++) begin
      if ($urandom_range(0, 15) == 0) ren = ~ren;
      if ($urandom_range(0, 5) == 0) rreq = ~rreq;
      if (!rreq) rh = ($urandom_range(0, 9) == 0) ? WIDTH'($urandom_range(0, 31))
                                                  : WIDTH'($urandom_range(0, 5));
      step_chk($sformatf("R[%0d]", k), ren, rreq, rh);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
